master_port: RTL and testbench
==============================

MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bus data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles waiting for read data.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port daddr  in  ADDR_WIDTH  parallel request address.
REQ-007 SHALL have port dwdata  in  DATA_WIDTH  parallel write data.
REQ-008 SHALL have port dmode  in  1  request type, 1=write, 0=read.
REQ-009 SHALL have port dvalid  in  1  request valid.
REQ-010 SHALL have port dready  out  1  high when idle, meaning a request can be accepted.
REQ-011 SHALL have port drdata  out  DATA_WIDTH  read result.
REQ-012 SHALL have port dack  out  1  one-cycle completion pulse.
REQ-013 SHALL have port derr  out  1  read timeout flag, valid with dack.
REQ-014 SHALL have port mwdata  out  1  serial address/write data to slave, LSB first.
REQ-015 SHALL have port mmode  out  1  bus mode to slave, 1=write, 0=read.
REQ-016 SHALL have port mvalid  out  1  master frame valid.
REQ-017 SHALL have port mrdata  in  1  serial read data from slave, LSB first.
REQ-018 SHALL have port svalid  in  1  slave read-data bit valid.
REQ-019 SHALL have port sready  in  1  slave able to start a new frame.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 The FSM SHALL have exactly these states: IDLE, ADDR, WDATA, RWAIT, RDATA, DONE.
REQ-022 IDLE: dready=1, mvalid=0; on the edge where dvalid=1 and sready=1, latch daddr, dwdata and dmode, clear the bit counter, and go to ADDR.
REQ-023 dvalid SHALL be ignored outside IDLE; latched values SHALL NOT change mid-frame.
REQ-024 ADDR: mvalid=1, mmode=latched mode, mwdata=addr[cnt] for cnt 0..ADDR_WIDTH-1, one bit per cycle; after the last bit, go to WDATA (write) or RWAIT (read), clearing cnt.
REQ-025 WDATA: mvalid=1, mmode=1, mwdata=data[cnt] for DATA_WIDTH cycles; then go to DONE.
REQ-026 RWAIT: mvalid=0, mmode=0; the first edge with svalid=1 SHALL capture mrdata as bit 0, then go to RDATA with cnt=1.
REQ-027 RDATA: each edge with svalid=1 shifts mrdata into bit cnt; cycles with svalid=0 SHALL stall without counting; after DATA_WIDTH bits, go to DONE.
REQ-028 The timeout counter SHALL run in RWAIT and RDATA and reset on every svalid=1 cycle; reaching TIMEOUT SHALL force DONE with derr=1 and drdata=0.
REQ-029 DONE: dack=1 for exactly one cycle; drdata holds the read value (read) or is unchanged (write); derr=0 unless timed out; next state is IDLE.
REQ-030 Write latency: mvalid high for exactly ADDR_WIDTH+DATA_WIDTH consecutive cycles starting the cycle after acceptance; dack follows in the next cycle.
REQ-031 Minimum spacing between accepts SHALL be one IDLE cycle after DONE.
REQ-032 mwdata SHALL be 0 whenever mvalid=0.
REQ-033 sready SHALL be checked only at acceptance; a sready drop mid-frame SHALL NOT abort the frame.
REQ-034 svalid seen in IDLE, ADDR or WDATA SHALL be ignored.

Reset
REQ-035 On an rstn=0 edge, from any state, the block SHALL go to IDLE with dready=1, mvalid=0, mmode=0, mwdata=0, dack=0, derr=0, drdata=0, and counters=0.
REQ-036 Reset mid-frame SHALL abandon the frame without a dack pulse.

Verification
REQ-037 Write: daddr=0x4D5, dwdata=0xD5, dmode=1, sready=1 -> mwdata 1,0,1,0,1,0,1,1,0,0,1,0 then 1,0,1,0,1,0,1,1 with mvalid high for 20 cycles, then one dack with derr=0.
REQ-038 Read: daddr=0x4D5, dmode=0; slave returns 0xA3 LSB first with svalid high for 8 cycles -> 12 address bits with mmode=0, then drdata=0xA3 and dack with derr=0.
REQ-039 Read with svalid gaps (bits 1,0 / gap of 3 cycles / remaining 6 bits of 0x5C) -> drdata=0x5C; gap cycles not counted.
REQ-040 Read with svalid never asserted -> dack with derr=1 and drdata=0 after 64 RWAIT cycles.
REQ-041 dvalid=1 with sready=0 -> no accept and mvalid stays 0; raising sready accepts on the next edge.
REQ-042 rstn=0 at the 5th address bit -> mvalid=0 and dready=1 on the next cycle, no dack; a following request completes normally.

Source files
------------

// File: rtl/master_port_if.sv
`default_nettype none
// ============================================================================
// Module     : master_port_if
// Purpose    : Bundles the parallel request port and the serial slave-bus
//              signals of master_port into a single interface.
// Ports      : (signals, direction seen from the master modport)
//   daddr   in  ADDR_WIDTH  request address
//   dwdata  in  DATA_WIDTH  request write data
//   dmode   in  1           1=write, 0=read
//   dvalid  in  1           request valid
//   dready  out 1           idle, request can be accepted
//   drdata  out DATA_WIDTH  read result
//   dack    out 1           one-cycle completion pulse
//   derr    out 1           read timeout flag, valid with dack
//   mwdata  out 1           serial address/write data, LSB first
//   mmode   out 1           bus mode, 1=write, 0=read
//   mvalid  out 1           frame bit valid
//   mrdata  in  1           serial read data, LSB first
//   svalid  in  1           read-data bit valid
//   sready  in  1           slave can start a new frame
// Revision   : 1.0 - initial release
// ============================================================================
interface master_port_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic                  dmode;
  logic                  dvalid;
  logic                  dready;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  dack;
  logic                  derr;
  logic                  mwdata;
  logic                  mmode;
  logic                  mvalid;
  logic                  mrdata;
  logic                  svalid;
  logic                  sready;

  // Bus master (the master_port block itself)
  modport master (
    input  daddr, dwdata, dmode, dvalid, mrdata, svalid, sready,
    output dready, drdata, dack, derr, mwdata, mmode, mvalid
  );

  // Environment side: request source plus serial slave
  modport slave (
    output daddr, dwdata, dmode, dvalid, mrdata, svalid, sready,
    input  dready, drdata, dack, derr, mwdata, mmode, mvalid
  );
endinterface
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
// Module     : master_port
// Purpose    : Converts parallel read/write requests into a serial bus frame.
//              A frame sends ADDR_WIDTH address bits (LSB first), then either
//              DATA_WIDTH write bits or collects DATA_WIDTH read bits from the
//              slave, qualified by svalid. Reads give up after TIMEOUT cycles
//              without svalid and report derr. Completion is a one-cycle dack.
// Ports      :
//   clk   in  1   clock, rising edge
//   rstn  in  1   synchronous active-low reset
//   bus   master_port_if.master  request port and serial bus (see interface)
// Revision   : 1.0 - initial release
// ============================================================================
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          rstn,
  master_port_if.master bus
);

  // One bit counter serves both address and data phases.
  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RWAIT = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [TMO_W-1:0]      tmo_q,     tmo_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
  logic                  mode_q,    mode_d;
  logic [DATA_WIDTH-1:0] rd_sh_q,   rd_sh_d;

  logic                  dready_q,  dready_d;
  logic [DATA_WIDTH-1:0] drdata_q,  drdata_d;
  logic                  dack_q,    dack_d;
  logic                  derr_q,    derr_d;
  logic                  mwdata_q,  mwdata_d;
  logic                  mmode_q,   mmode_d;
  logic                  mvalid_q,  mvalid_d;

  // Read shift register with the current mrdata entering at the top; after
  // DATA_WIDTH accepted bits the first bit received sits at bit 0.
  logic [DATA_WIDTH-1:0] rd_shift;

  // All outputs are registered: each *_d is the value the output must show
  // while the FSM sits in state_d.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    mode_d    = mode_q;
    rd_sh_d   = rd_sh_q;
    dready_d  = 1'b0;
    drdata_d  = drdata_q;
    dack_d    = 1'b0;
    derr_d    = 1'b0;
    mwdata_d  = 1'b0;
    mmode_d   = 1'b0;
    mvalid_d  = 1'b0;

    rd_shift               = rd_sh_q >> 1;
    rd_shift[DATA_WIDTH-1] = bus.mrdata;

    case (state_q)
      IDLE: begin
        dready_d = 1'b1;
        if (bus.dvalid && bus.sready) begin
          state_d   = ADDR;
          cnt_d     = '0;
          tmo_d     = '0;
          // Bit 0 goes straight to the output; the rest wait in the shifter.
          addr_sh_d = bus.daddr >> 1;
          data_sh_d = bus.dwdata;
          mode_d    = bus.dmode;
          rd_sh_d   = '0;
          dready_d  = 1'b0;
          mvalid_d  = 1'b1;
          mmode_d   = bus.dmode;
          mwdata_d  = bus.daddr[0];
        end
      end

      ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d   = WDATA;
            mvalid_d  = 1'b1;
            mmode_d   = 1'b1;
            mwdata_d  = data_sh_q[0];
            data_sh_d = data_sh_q >> 1;
          end else begin
            state_d = RWAIT;
            tmo_d   = '0;
          end
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
          mvalid_d  = 1'b1;
          mmode_d   = mode_q;
          mwdata_d  = addr_sh_q[0];
          addr_sh_d = addr_sh_q >> 1;
        end
      end

      WDATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          dack_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
          mvalid_d  = 1'b1;
          mmode_d   = 1'b1;
          mwdata_d  = data_sh_q[0];
          data_sh_d = data_sh_q >> 1;
        end
      end

      // RWAIT waits for the first bit (cnt is 0 there); RDATA collects the
      // rest. Both stall on svalid=0 and share the inactivity timeout.
      RWAIT, RDATA: begin
        if (bus.svalid) begin
          tmo_d   = '0;
          rd_sh_d = rd_shift;
          if (cnt_q == DATA_LAST) begin
            state_d  = DONE;
            cnt_d    = '0;
            dack_d   = 1'b1;
            drdata_d = rd_shift;
          end else begin
            state_d = RDATA;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          tmo_d    = '0;
          dack_d   = 1'b1;
          derr_d   = 1'b1;
          drdata_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      DONE: begin
        state_d  = IDLE;
        dready_d = 1'b1;
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        tmo_d    = '0;
        dready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      mode_q    <= 1'b0;
      rd_sh_q   <= '0;
      dready_q  <= 1'b1;
      drdata_q  <= '0;
      dack_q    <= 1'b0;
      derr_q    <= 1'b0;
      mwdata_q  <= 1'b0;
      mmode_q   <= 1'b0;
      mvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      mode_q    <= mode_d;
      rd_sh_q   <= rd_sh_d;
      dready_q  <= dready_d;
      drdata_q  <= drdata_d;
      dack_q    <= dack_d;
      derr_q    <= derr_d;
      mwdata_q  <= mwdata_d;
      mmode_q   <= mmode_d;
      mvalid_q  <= mvalid_d;
    end
  end

  assign bus.dready = dready_q;
  assign bus.drdata = drdata_q;
  assign bus.dack   = dack_q;
  assign bus.derr   = derr_q;
  assign bus.mwdata = mwdata_q;
  assign bus.mmode  = mmode_q;
  assign bus.mvalid = mvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
// Module     : tb_master_port
// Purpose    : Self-checking bench for master_port. Stimulus tasks push the
//              expected serial bits and completion responses into queues; a
//              negedge monitor pops and compares whenever the DUT shows
//              mvalid or dack.
// Ports      : none
// Revision   : 1.0 - initial release
// ============================================================================
module tb_master_port;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  master_port #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int tests    = 0;
  int fails    = 0;
  int ncyc     = 0;
  int dack_cnt = 0;
  int dack_cyc = 0;

  logic [1:0]    exp_bits[$];   // {mmode, mwdata} per mvalid cycle
  logic [DW:0]   exp_resp[$];   // {derr, drdata} per dack
  logic [1:0]    eb;
  logic [DW:0]   er;
  logic          prev_dack = 1'b0;
  logic [DW-1:0] last_rd   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    ncyc++;
    if (bus.mvalid === 1'b1) begin
      if (exp_bits.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL serial_unexpected: mmode=%b mwdata=%b with no bit expected (cycle %0d)",
                 bus.mmode, bus.mwdata, ncyc);
      end else begin
        eb = exp_bits.pop_front();
        check("serial_bit", {30'd0, bus.mmode, bus.mwdata}, {30'd0, eb});
      end
    end else begin
      check("mwdata_zero_idle", {31'd0, bus.mwdata}, 32'd0);
    end
    if (bus.dack === 1'b1) begin
      dack_cnt++;
      dack_cyc = ncyc;
      check("dack_one_cycle", {31'd0, prev_dack}, 32'd0);
      if (exp_resp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: derr=%b drdata=0x%0h with no response expected",
                 bus.derr, bus.drdata);
      end else begin
        er = exp_resp.pop_front();
        check("resp_derr_drdata", {23'd0, bus.derr, bus.drdata}, {23'd0, er});
      end
    end
    prev_dack = bus.dack;
  end

  task automatic push_addr(input logic [AW-1:0] a, input logic m);
    for (int i = 0; i < AW; i++) exp_bits.push_back({m, a[i]});
  endtask

  // Presents a request; returns the negedge count just before the accept edge.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic m,
                       input int low_cyc, output int acc);
    @(posedge clk); #1;
    bus.daddr  = a;
    bus.dwdata = d;
    bus.dmode  = m;
    bus.dvalid = 1'b1;
    if (low_cyc > 0) begin
      bus.sready = 1'b0;
      for (int i = 0; i < low_cyc; i++) begin
        @(negedge clk);
        check("sready_low_dready", {31'd0, bus.dready}, 32'd1);
        check("sready_low_mvalid", {31'd0, bus.mvalid}, 32'd0);
      end
      @(posedge clk); #1;
      bus.sready = 1'b1;
    end
    @(posedge clk); #1;
    acc        = ncyc;
    bus.dvalid = 1'b0;
    // Scramble inputs: the frame must use the latched copies.
    bus.daddr  = ~a;
    bus.dwdata = ~d;
    bus.dmode  = ~m;
  endtask

  task automatic wait_dack(input int start, input int limit);
    #1;
    for (int i = 0; i < limit; i++) begin
      if (dack_cnt != start) break;
      @(negedge clk); #1;
    end
    if (dack_cnt == start) begin
      tests++;
      fails++;
      $display("FAIL dack_timeout: no dack within %0d cycles", limit);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit sv_noise, input int low_cyc);
    int acc;
    int start;
    push_addr(a, 1'b1);
    for (int i = 0; i < DW; i++) exp_bits.push_back({1'b1, d[i]});
    exp_resp.push_back({1'b0, last_rd});
    start = dack_cnt;
    if (sv_noise) begin
      bus.svalid = 1'b1;
      bus.mrdata = 1'b1;
    end
    issue(a, d, 1'b1, low_cyc, acc);
    wait_dack(start, AW + DW + 10);
    check("write_latency", dack_cyc - acc, AW + DW + 1);
    check("write_bits_consumed", exp_bits.size(), 32'd0);
    bus.svalid = 1'b0;
    bus.mrdata = 1'b0;
  endtask

  // gap_at: index of the read bit preceded by gap_len svalid=0 cycles.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] val,
                         input int gap_at, input int gap_len, input bit no_data);
    int acc;
    int start;
    int gap;
    push_addr(a, 1'b0);
    if (no_data) begin
      exp_resp.push_back({1'b1, {DW{1'b0}}});
      last_rd = '0;
    end else begin
      exp_resp.push_back({1'b0, val});
      last_rd = val;
    end
    start = dack_cnt;
    issue(a, '0, 1'b0, 0, acc);
    repeat (AW) @(posedge clk);
    @(negedge clk);                    // first RWAIT cycle
    gap = 0;
    if (!no_data) begin
      for (int i = 0; i < DW; i++) begin
        if (i == gap_at) begin
          bus.svalid = 1'b0;
          bus.mrdata = 1'b1;
          repeat (gap_len) @(negedge clk);
          gap = gap_len;
        end
        bus.svalid = 1'b1;
        bus.mrdata = val[i];
        @(negedge clk);
      end
    end
    bus.svalid = 1'b0;
    bus.mrdata = 1'b0;
    wait_dack(start, TMO + 20);
    if (no_data) check("timeout_latency", dack_cyc - acc, AW + TMO + 1);
    else         check("read_latency", dack_cyc - acc, AW + DW + gap + 1);
    check("read_bits_consumed", exp_bits.size(), 32'd0);
  endtask

  task automatic reset_mid_frame(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int acc;
    int start;
    for (int i = 0; i < 5; i++) exp_bits.push_back({1'b1, a[i]});
    start = dack_cnt;
    issue(a, d, 1'b1, 0, acc);
    repeat (4) begin @(posedge clk); #1; end   // now inside cycle showing bit 4
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("reset_mid_mvalid", {31'd0, bus.mvalid}, 32'd0);
    check("reset_mid_dready", {31'd0, bus.dready}, 32'd1);
    repeat (5) @(negedge clk);
    check("reset_mid_no_dack", dack_cnt, start);
    check("reset_mid_bits", exp_bits.size(), 32'd0);
    last_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.daddr  = '0;
    bus.dwdata = '0;
    bus.dmode  = 1'b0;
    bus.dvalid = 1'b0;
    bus.mrdata = 1'b0;
    bus.svalid = 1'b0;
    bus.sready = 1'b1;
    rstn       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dready", {31'd0, bus.dready}, 32'd1);
    check("reset_mvalid", {31'd0, bus.mvalid}, 32'd0);
    check("reset_mmode",  {31'd0, bus.mmode},  32'd0);
    check("reset_dack",   {31'd0, bus.dack},   32'd0);
    check("reset_derr",   {31'd0, bus.derr},   32'd0);
    check("reset_drdata", {24'd0, bus.drdata}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    do_write(12'h4D5, 8'hD5, 1'b0, 0);      // reference write
    do_read (12'h4D5, 8'hA3, DW, 0, 1'b0);  // reference read, no gaps
    do_write(12'hFFF, 8'h00, 1'b1, 0);      // svalid noise ignored, drdata held at A3
    do_read (12'h000, 8'h5C, 2, 3, 1'b0);   // 3-cycle gap after two bits
    do_read (12'h123, 8'h00, DW, 0, 1'b1);  // no svalid: timeout
    do_write(12'h0F0, 8'h81, 1'b0, 4);      // held off by sready=0
    reset_mid_frame(12'hA5A, 8'h3C);
    do_write(12'hA5A, 8'h3C, 1'b0, 0);      // clean frame after reset
    do_read (12'h800, 8'hFF, DW, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("final_bits_empty", exp_bits.size(), 32'd0);
    check("final_resp_empty", exp_resp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
